// File: rtl/gol_grid_engine.sv
// gol_grid_engine
//   Computes one Game of Life generation per start request. It acts as an
//   Avalon-MM master on port s2 of the dual-port grid RAM (1-cycle read
//   latency). For each cell it reads the 3x3 toroidal neighbourhood from the
//   source bank and writes the next-state byte (8'h01 / 8'h00) to the
//   destination bank. Cells are visited row-major, 11 cycles per cell.
// Ports
//   clk, reset_n      clock; asynchronous active-low reset
//   start, swap       start request; swap selects bank1->bank0 when 1
//   busy, done        run in progress; 1-cycle completion pulse
//   gen_count         completed generations (wraps)
//   mem_*             RAM port-2 master signals; mem_readdata returns data
//                     one cycle after its address
module gol_grid_engine #(
   parameter int unsigned GRID_W     = 32,
   parameter int unsigned GRID_H     = 32,
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned BANK0_BASE = 0,
   parameter int unsigned BANK1_BASE = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              swap,
   output logic              busy,
   output logic              done,
   output logic [15:0]       gen_count,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [7:0]        mem_writedata,
   output logic              mem_clken,
   input  logic [7:0]        mem_readdata
);

   localparam int unsigned XW = $clog2(GRID_W);
   localparam int unsigned YW = $clog2(GRID_H);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_TAIL, S_WRITE, S_DONE} state_t;

   state_t            state_q;
   logic [3:0]        k_q;
   logic [XW-1:0]     x_q;
   logic [YW-1:0]     y_q;
   logic [3:0]        n_q;
   logic              centre_q;
   logic              swap_q;
   logic              busy_q;
   logic              done_q;
   logic [15:0]       gen_q;
   logic [ADDR_W-1:0] addr_q;
   logic              cs_q;
   logic              wr_q;
   logic [7:0]        wdata_q;

   logic [XW-1:0]     x_d;
   logic [YW-1:0]     y_d;
   logic              last_cell;
   logic [ADDR_W-1:0] src_base;
   logic [ADDR_W-1:0] dst_base;
   logic [ADDR_W-1:0] start_base;
   logic              rd_alive;
   logic [3:0]        n_tail;
   logic              next_alive;

   // Neighbour k = 3*(dy+1) + (dx+1); wrap comes free from the power-of-two
   // coordinate widths, and y*GRID_W + x is just the concatenation {y, x}.
   function automatic logic [ADDR_W-1:0] nbr_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [XW-1:0] x,
                                                  input logic [YW-1:0] y,
                                                  input logic [3:0] k);
      logic [XW-1:0] xs;
      logic [YW-1:0] ys;
      case (k)
         4'd0, 4'd3, 4'd6: xs = x - XW'(1);
         4'd2, 4'd5, 4'd8: xs = x + XW'(1);
         default:          xs = x;
      endcase
      case (k)
         4'd0, 4'd1, 4'd2: ys = y - YW'(1);
         4'd6, 4'd7, 4'd8: ys = y + YW'(1);
         default:          ys = y;
      endcase
      return base + ADDR_W'({ys, xs});
   endfunction

   always_comb begin
      x_d        = x_q + XW'(1);
      y_d        = (x_q == XW'(GRID_W - 1)) ? y_q + YW'(1) : y_q;
      last_cell  = (x_q == XW'(GRID_W - 1)) && (y_q == YW'(GRID_H - 1));
      src_base   = swap_q ? ADDR_W'(BANK1_BASE) : ADDR_W'(BANK0_BASE);
      dst_base   = swap_q ? ADDR_W'(BANK0_BASE) : ADDR_W'(BANK1_BASE);
      start_base = swap   ? ADDR_W'(BANK1_BASE) : ADDR_W'(BANK0_BASE);
      rd_alive   = |mem_readdata;
      n_tail     = n_q + {3'b000, rd_alive};
      next_alive = (n_tail == 4'd3) || (centre_q && (n_tail == 4'd2));
   end

   // Outputs are registered: each branch loads the values the next state presents.
   // Data returned during READ belongs to the address issued one cycle earlier (k-1).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         k_q      <= '0;
         x_q      <= '0;
         y_q      <= '0;
         n_q      <= '0;
         centre_q <= 1'b0;
         swap_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         gen_q    <= '0;
         addr_q   <= '0;
         cs_q     <= 1'b0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  swap_q   <= swap;
                  x_q      <= '0;
                  y_q      <= '0;
                  k_q      <= '0;
                  n_q      <= '0;
                  centre_q <= 1'b0;
                  busy_q   <= 1'b1;
                  cs_q     <= 1'b1;
                  wr_q     <= 1'b0;
                  addr_q   <= nbr_addr(start_base, '0, '0, 4'd0);
                  state_q  <= S_READ;
               end
            end
            S_READ: begin
               if (k_q != 4'd0) begin
                  if (k_q == 4'd5) centre_q <= rd_alive;
                  else             n_q      <= n_q + {3'b000, rd_alive};
               end
               if (k_q == 4'd8) begin
                  cs_q    <= 1'b0;
                  state_q <= S_TAIL;
               end else begin
                  k_q    <= k_q + 4'd1;
                  addr_q <= nbr_addr(src_base, x_q, y_q, k_q + 4'd1);
               end
            end
            S_TAIL: begin
               cs_q    <= 1'b1;
               wr_q    <= 1'b1;
               addr_q  <= dst_base + ADDR_W'({y_q, x_q});
               wdata_q <= {7'b0000000, next_alive};
               state_q <= S_WRITE;
            end
            S_WRITE: begin
               wr_q <= 1'b0;
               x_q  <= x_d;
               y_q  <= y_d;
               if (last_cell) begin
                  cs_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  gen_q   <= gen_q + 16'd1;
                  state_q <= S_DONE;
               end else begin
                  k_q      <= '0;
                  n_q      <= '0;
                  centre_q <= 1'b0;
                  cs_q     <= 1'b1;
                  addr_q   <= nbr_addr(src_base, x_d, y_d, 4'd0);
                  state_q  <= S_READ;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign gen_count      = gen_q;
   assign mem_address    = addr_q;
   assign mem_chipselect = cs_q;
   assign mem_write      = wr_q;
   assign mem_writedata  = wdata_q;
   assign mem_clken      = reset_n;

endmodule
